// File: rtl/tcp_vlg_rx_fifo.sv
// Receive byte buffer behind the TCP stack's user data output.
// Burst-tagged show-ahead FIFO with overflow accounting and disconnect flush.
module tcp_vlg_rx_fifo #(
    parameter int DEPTH_LOG2    = 10,
    parameter int AFULL_MARGIN  = 64,
    parameter int GAP_TICKS     = 32,
    parameter bit FLUSH_ON_DISC = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  connected,
    input  logic                  vin,
    input  logic [7:0]            din,
    output logic [7:0]            out_d,
    output logic                  out_sob,
    output logic                  out_v,
    input  logic                  out_rdy,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  almost_full,
    output logic                  ovf,
    output logic [15:0]           ovf_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int GW    = $clog2(GAP_TICKS + 1);

    typedef logic [DEPTH_LOG2:0] lvl_t;

    localparam lvl_t FULL_LVL = lvl_t'(DEPTH);
    localparam lvl_t AF_LVL   = lvl_t'(DEPTH - AFULL_MARGIN);

    logic [8:0]            mem [DEPTH];
    logic [8:0]            rd_q;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  conn_q;
    logic                  sob_pend;
    logic [GW-1:0]         gap_cnt;

    logic full;
    logic flush;
    logic rise;
    logic we;
    logic drop;
    logic pop;
    logic load;
    logic gap_hit;
    lvl_t ram_cnt;
    lvl_t level_nxt;

    assign full      = (level == FULL_LVL);
    assign flush     = FLUSH_ON_DISC && conn_q && !connected;
    assign rise      = connected && !conn_q;
    assign we        = vin && !full && !flush;
    assign drop      = vin && full && !flush;
    assign pop       = out_v && out_rdy;
    assign ram_cnt   = level - lvl_t'(out_v);
    assign load      = (ram_cnt != '0) && (!out_v || out_rdy);
    assign level_nxt = level + lvl_t'(we) - lvl_t'(pop);
    assign gap_hit   = !vin && (gap_cnt >= GW'(GAP_TICKS - 1));

    // Registered RAM read port doubles as the show-ahead output register.
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_ptr] <= {sob_pend, din};
        if (load)
            rd_q <= mem[rd_ptr];
    end

    assign out_d   = out_v ? rd_q[7:0] : 8'h00;
    assign out_sob = out_v ? rd_q[8]   : 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            out_v       <= 1'b0;
            almost_full <= 1'b0;
            ovf         <= 1'b0;
            ovf_cnt     <= '0;
            conn_q      <= 1'b0;
            sob_pend    <= 1'b1;
            gap_cnt     <= '0;
        end else begin
            conn_q <= connected;

            if (vin)
                gap_cnt <= '0;
            else if (gap_cnt != GW'(GAP_TICKS))
                gap_cnt <= gap_cnt + GW'(1);

            if (flush) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                level       <= '0;
                out_v       <= 1'b0;
                almost_full <= 1'b0;
                ovf         <= 1'b0;
                ovf_cnt     <= '0;
                sob_pend    <= 1'b1;
            end else begin
                level       <= level_nxt;
                almost_full <= (level_nxt >= AF_LVL);

                if (we) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    sob_pend <= 1'b0;
                end
                // A new burst starts after a long idle gap or a reconnect.
                if (rise || gap_hit)
                    sob_pend <= 1'b1;

                if (load)
                    rd_ptr <= rd_ptr + 1'b1;

                if (load)
                    out_v <= 1'b1;
                else if (pop)
                    out_v <= 1'b0;

                if (drop) begin
                    ovf <= 1'b1;
                    if (ovf_cnt != 16'hFFFF)
                        ovf_cnt <= ovf_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tcp_vlg_rx_fifo.sv
// Directed scoreboard bench for tcp_vlg_rx_fifo (16-entry FIFO plus a
// no-flush twin instance for the keep-on-disconnect case).
module tb_tcp_vlg_rx_fifo;

    localparam int DL   = 4;
    localparam int DEP  = 1 << DL;
    localparam int AFM  = 4;
    localparam int GAP  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          connected;
    logic          vin;
    logic [7:0]    din;
    logic          out_rdy;
    logic [7:0]    out_d;
    logic          out_sob;
    logic          out_v;
    logic [DL:0]   level;
    logic          almost_full;
    logic          ovf;
    logic [15:0]   ovf_cnt;

    logic          rdy_k;
    logic [7:0]    k_out_d;
    logic          k_out_sob;
    logic          k_out_v;
    logic [DL:0]   k_level;
    logic          k_af;
    logic          k_ovf;
    logic [15:0]   k_ovf_cnt;

    always #5 clk = ~clk;

    tcp_vlg_rx_fifo #(
        .DEPTH_LOG2(DL), .AFULL_MARGIN(AFM),
        .GAP_TICKS(GAP), .FLUSH_ON_DISC(1'b1)
    ) u_dut (
        .clk(clk), .rst(rst), .connected(connected),
        .vin(vin), .din(din),
        .out_d(out_d), .out_sob(out_sob), .out_v(out_v),
        .out_rdy(out_rdy), .level(level),
        .almost_full(almost_full), .ovf(ovf), .ovf_cnt(ovf_cnt)
    );

    tcp_vlg_rx_fifo #(
        .DEPTH_LOG2(DL), .AFULL_MARGIN(AFM),
        .GAP_TICKS(GAP), .FLUSH_ON_DISC(1'b0)
    ) u_keep (
        .clk(clk), .rst(rst), .connected(connected),
        .vin(vin), .din(din),
        .out_d(k_out_d), .out_sob(k_out_sob), .out_v(k_out_v),
        .out_rdy(rdy_k), .level(k_level),
        .almost_full(k_af), .ovf(k_ovf), .ovf_cnt(k_ovf_cnt)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         n_sob_seen = 0;
    logic [8:0] q[$];
    logic [7:0] qk[$];
    logic       m_sob = 1'b1;
    int         m_idle = 0;
    int         m_drops = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, score the pre-edge handshake, update model.
    task automatic cyc(input logic v, input logic [7:0] d, input logic r);
        logic       hs;
        logic       stall;
        logic [8:0] held;
        logic [8:0] e;
        int         pre;
        vin     = v;
        din     = d;
        out_rdy = r;
        hs      = out_v && r;
        stall   = out_v && !r;
        held    = {out_sob, out_d};
        pre     = q.size();
        if (hs) begin
            if (out_sob) n_sob_seen++;
            if (q.size() == 0) begin
                chk("extra_out", q.size(), 1);
            end else begin
                e = q.pop_front();
                chk("out_data", {out_sob, out_d}, e);
            end
        end
        if (v) begin
            m_idle = 0;
            if (pre < DEP) begin
                q.push_back({m_sob, d});
                m_sob = 1'b0;
            end else begin
                m_drops++;
            end
        end else begin
            if (m_idle < GAP) m_idle++;
            if (m_idle >= GAP) m_sob = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("level", level, q.size());
        chk("afull", almost_full, q.size() >= DEP - AFM);
        if (stall)
            chk("stall_hold", {out_v, out_sob, out_d}, {1'b1, held});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (q.size() != 0 || out_v); i++)
            cyc(1'b0, 8'h00, 1'b1);
        chk("drain_done", q.size(), 0);
        chk("drain_outv", out_v, 0);
    endtask

    initial begin
        int         s0;
        int         sent;
        logic [7:0] b;
        logic [7:0] ek;
        logic       v;
        logic       r;

        rst = 1'b0; connected = 1'b0; vin = 1'b0;
        din = 8'h00; out_rdy = 1'b0; rdy_k = 1'b1;
        #3;
        chk("rst_outv", out_v, 0);
        chk("rst_outd", out_d, 0);
        chk("rst_sob", out_sob, 0);
        chk("rst_level", level, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ovfcnt", ovf_cnt, 0);
        #9;
        rst = 1'b1;
        @(posedge clk); #1;
        connected = 1'b1;
        idle(2);

        // Single burst with latency check.
        s0 = n_sob_seen;
        for (int i = 0; i < 16; i++) begin
            b = 8'(8'h10 + i);
            cyc(1'b1, b, 1'b1);
            if (i == 0) chk("lat_n1_outv", out_v, 0);
            if (i == 1) chk("lat_n2", {out_v, out_d}, {1'b1, 8'h10});
        end
        drain();
        chk("burst_sob_count", n_sob_seen - s0, 1);

        // Gap framing: full gap starts a new burst.
        idle(GAP);
        s0 = n_sob_seen;
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h20 + i), 1'b1);
        idle(GAP);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h24 + i), 1'b1);
        drain();
        chk("gap_sob_count", n_sob_seen - s0, 2);

        // One cycle short of the gap keeps the burst going.
        idle(GAP);
        s0 = n_sob_seen;
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h30 + i), 1'b1);
        idle(GAP - 1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h34 + i), 1'b1);
        drain();
        chk("short_gap_sob_count", n_sob_seen - s0, 1);

        // Overflow.
        idle(GAP);
        chk("pre_ovf", ovf, 0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'(i), 1'b0);
        chk("ovf_level", level, 16);
        chk("ovf_afull", almost_full, 1);
        chk("ovf_flag", ovf, 1);
        chk("ovf_cnt", ovf_cnt, 4);
        drain();
        chk("ovf_sticky", {ovf, ovf_cnt}, {1'b1, 16'd4});

        // Random backpressure stream.
        idle(GAP);
        sent = 0;
        for (int c = 0; c < 6000 && sent < 1000; c++) begin
            v = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 9) < 6);
            b = sent[7:0];
            cyc(v, b, r);
            if (v) sent++;
        end
        chk("bp_sent", sent, 1000);
        drain();

        // Disconnect flush, with the no-flush twin keeping its data.
        idle(GAP);
        chk("keep_pre_empty", k_level, 0);
        rdy_k = 1'b0;
        qk.delete();
        for (int i = 0; i < 10; i++) begin
            b = 8'(8'hA0 + i);
            cyc(1'b1, b, 1'b0);
            qk.push_back(b);
        end
        chk("pre_flush_ovfcnt", ovf_cnt, 4);
        connected = 1'b0; vin = 1'b1; din = 8'hEE; out_rdy = 1'b0;
        @(posedge clk); #1;
        qk.push_back(8'hEE);
        q.delete(); m_drops = 0; m_sob = 1'b1; m_idle = 0;
        chk("flush_level", level, 0);
        chk("flush_outv", out_v, 0);
        chk("flush_ovfcnt", ovf_cnt, 0);
        chk("flush_ovf", ovf, 0);
        chk("keep_level", k_level, 11);
        chk("keep_outv", k_out_v, 1);
        connected = 1'b1;
        cyc(1'b0, 8'h00, 1'b1);
        s0 = n_sob_seen;
        cyc(1'b1, 8'h55, 1'b1);
        cyc(1'b1, 8'h56, 1'b1);
        qk.push_back(8'h55);
        qk.push_back(8'h56);
        rdy_k = 1'b1;
        for (int i = 0; i < 40 && qk.size() != 0; i++) begin
            if (k_out_v) begin
                ek = qk.pop_front();
                chk("keep_data", k_out_d, ek);
            end
            cyc(1'b0, 8'h00, 1'b1);
        end
        chk("keep_empty", qk.size(), 0);
        drain();
        chk("reconn_sob_count", n_sob_seen - s0, 1);

        // Asynchronous reset mid-stream.
        idle(GAP);
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
        chk("pre_rst_out", {out_v, out_d}, {1'b1, 8'hC0});
        #2;
        rst = 1'b0;
        #1;
        chk("arst_outv", out_v, 0);
        chk("arst_outd", out_d, 0);
        chk("arst_sob", out_sob, 0);
        chk("arst_level", level, 0);
        chk("arst_afull", almost_full, 0);
        chk("arst_ovfcnt", {ovf, ovf_cnt}, 0);
        q.delete(); qk.delete();
        m_sob = 1'b1; m_idle = 0; m_drops = 0;
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b1);
        s0 = n_sob_seen;
        cyc(1'b1, 8'h77, 1'b1);
        cyc(1'b1, 8'h78, 1'b1);
        drain();
        chk("post_rst_sob_count", n_sob_seen - s0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
